// File: rtl/hams_pkg.sv
// Shared types and constants for the HAMS merge-phase scheduler.
// Job bundle layout matches the engine's job port fields.
package hams_pkg;

  localparam int HAMS_MERGE_AW = 10;
  localparam int HAMS_MERGE_MAX_INFLIGHT = 2;

  typedef struct packed {
    logic [HAMS_MERGE_AW-1:0] src_a;
    logic [HAMS_MERGE_AW-1:0] src_b;
    logic [HAMS_MERGE_AW-1:0] dst;
    logic [HAMS_MERGE_AW-1:0] run_len;
  } merge_job_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PH1,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } merge_state_t;

  function automatic logic legal_rows(
    input logic [HAMS_MERGE_AW-1:0] n,
    input logic [HAMS_MERGE_AW-1:0] lim
  );
    return (n != '0) && ((n & (n - 1'b1)) == '0) && (n <= lim);
  endfunction

endpackage

// File: rtl/hams_merge_sched_if.sv
// Job handshake between the merge scheduler and the merge engine.
// The scheduler is master; the engine accepts jobs and pulses done.
interface hams_merge_sched_if
  import hams_pkg::*;
#(
  parameter int ADDR_WIDTH = HAMS_MERGE_AW
);
  logic                  job_valid;
  logic                  job_ready;
  logic                  job_done;
  logic [ADDR_WIDTH-1:0] job_src_a;
  logic [ADDR_WIDTH-1:0] job_src_b;
  logic [ADDR_WIDTH-1:0] job_dst;
  logic [ADDR_WIDTH-1:0] job_run_len;

  modport master (
    output job_valid, job_src_a, job_src_b,
    output job_dst, job_run_len,
    input  job_ready, job_done
  );

  modport slave (
    input  job_valid, job_src_a, job_src_b,
    input  job_dst, job_run_len,
    output job_ready, job_done
  );
endinterface

// File: rtl/hams_merge_jobgen.sv
// Per-pass job offset counter and merge-job address generator.
// off tracks 2*run_len*k for the next job to be presented.
module hams_merge_jobgen
  import hams_pkg::*;
#(
  parameter int ADDR_WIDTH = HAMS_MERGE_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] load_off,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH-1:0] run_len,
  input  logic [ADDR_WIDTH-1:0] num_rows,
  output merge_job_t            job,
  output logic                  last
);
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] step;

  assign step = run_len << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off <= '0;
    end else if (load) begin
      off <= load_off;
    end else if (advance) begin
      off <= off + step;
    end
  end

  assign job.src_a   = src_base + off;
  assign job.src_b   = src_base + off + run_len;
  assign job.dst     = dst_base + off;
  assign job.run_len = run_len;
  assign last        = (off + step) == num_rows;
endmodule

// File: rtl/hams_merge_sched.sv
// Merge-phase scheduler: sequences log2(num_rows) ping-pong merge
// passes and issues jobs to the merge engine with bounded inflight.
module hams_merge_sched
  import hams_pkg::*;
#(
  parameter int MEM_DEPTH    = 1 << HAMS_MERGE_AW,
  parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int MAX_INFLIGHT = HAMS_MERGE_MAX_INFLIGHT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic [ADDR_WIDTH-1:0] num_rows,
  input  logic                  ph1_done,
  hams_merge_sched_if.master    jif,
  output logic [3:0]            pass_idx,
  output logic                  busy,
  output logic                  merge_done,
  output logic [ADDR_WIDTH-1:0] result_base,
  output logic                  err
);
  localparam int DATA_ROWS = MEM_DEPTH / 2;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [ADDR_WIDTH-1:0] DROWS = ADDR_WIDTH'(DATA_ROWS);

  merge_state_t state, state_n;

  logic [ADDR_WIDTH-1:0] nrows, run_len, src_base, dst_base;
  logic [ADDR_WIDTH-1:0] step, rl_n, sb_n, db_n, load_off;
  logic [IW-1:0] inflight, inflight_n;
  logic valid_q, pres_last, gen_last, first_last;
  logic accept, done_ok, can_offer, load;
  logic start_pass, next_pass, finish;
  logic offer_first, offer_gen;
  merge_job_t job_q, gen_job, first_job;

  assign accept  = jif.job_valid && jif.job_ready;
  assign done_ok = jif.job_done && (inflight != '0);
  assign step    = run_len << 1;

  assign inflight_n = inflight + IW'(accept) - IW'(done_ok);
  assign can_offer  = !pause
                   && (inflight_n < IW'(MAX_INFLIGHT))
                   && (!valid_q || accept);

  always_comb begin
    state_n    = state;
    start_pass = 1'b0;
    next_pass  = 1'b0;
    finish     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (legal_rows(num_rows, DROWS)) state_n = S_WAIT_PH1;
          else state_n = S_DONE;
        end
      end
      S_WAIT_PH1: begin
        if (ph1_done) begin
          if (nrows == ADDR_WIDTH'(1)) begin
            state_n = S_DONE;
          end else begin
            state_n    = S_ISSUE;
            start_pass = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (accept && pres_last) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight == '0) begin
          if (step == nrows) begin
            state_n = S_DONE;
            finish  = 1'b1;
          end else begin
            state_n   = S_ISSUE;
            next_pass = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!start) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Job 0 of a new pass is built from the next-pass bases so it can
  // be presented in the same cycle the pass starts.
  always_comb begin
    rl_n = ADDR_WIDTH'(1);
    sb_n = '0;
    db_n = DROWS;
    if (next_pass) begin
      rl_n = step;
      sb_n = dst_base;
      db_n = src_base;
    end
  end

  assign first_job.src_a   = sb_n;
  assign first_job.src_b   = sb_n + rl_n;
  assign first_job.dst     = db_n;
  assign first_job.run_len = rl_n;
  assign first_last        = (rl_n << 1) == nrows;

  assign load        = start_pass || next_pass;
  assign offer_first = load && can_offer;
  assign offer_gen   = (state == S_ISSUE) && !pres_last && can_offer;
  assign load_off    = offer_first ? (rl_n << 1) : '0;

  hams_merge_jobgen #(.ADDR_WIDTH(ADDR_WIDTH)) u_jobgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .advance  (offer_gen),
    .load_off (load_off),
    .src_base (src_base),
    .dst_base (dst_base),
    .run_len  (run_len),
    .num_rows (nrows),
    .job      (gen_job),
    .last     (gen_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nrows       <= '0;
      run_len     <= '0;
      src_base    <= '0;
      dst_base    <= '0;
      inflight    <= '0;
      valid_q     <= 1'b0;
      pres_last   <= 1'b0;
      job_q       <= '0;
      pass_idx    <= '0;
      result_base <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      merge_done  <= 1'b0;
    end else begin
      inflight   <= inflight_n;
      busy       <= (state_n != S_IDLE) && (state_n != S_DONE);
      merge_done <= state_n == S_DONE;
      if (state == S_IDLE && start) begin
        nrows       <= num_rows;
        pass_idx    <= '0;
        result_base <= '0;
        err         <= !legal_rows(num_rows, DROWS);
      end
      // A done with nothing outstanding is dropped but flagged.
      if (jif.job_done && inflight == '0) err <= 1'b1;
      if (load) begin
        run_len   <= rl_n;
        src_base  <= sb_n;
        dst_base  <= db_n;
        pres_last <= offer_first && first_last;
      end
      if (next_pass) pass_idx <= pass_idx + 4'd1;
      if (finish) result_base <= dst_base;
      if (offer_first) begin
        job_q   <= first_job;
        valid_q <= 1'b1;
      end else if (offer_gen) begin
        job_q     <= gen_job;
        valid_q   <= 1'b1;
        pres_last <= gen_last;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign jif.job_valid   = valid_q;
  assign jif.job_src_a   = job_q.src_a;
  assign jif.job_src_b   = job_q.src_b;
  assign jif.job_dst     = job_q.dst;
  assign jif.job_run_len = job_q.run_len;
endmodule

// File: tb/tb_hams_merge_sched.sv
// Directed scoreboard bench for hams_merge_sched.
// A monitor pops expected jobs on every accepted handshake.
module tb_hams_merge_sched;
  import hams_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic ph1_done = 1'b0;
  logic [AW-1:0] num_rows = '0;
  logic [3:0] pass_idx;
  logic busy, merge_done, err;
  logic [AW-1:0] result_base;

  hams_merge_sched_if #(.ADDR_WIDTH(AW)) jif ();

  hams_merge_sched #(
    .MEM_DEPTH(1024),
    .ADDR_WIDTH(AW),
    .MAX_INFLIGHT(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .num_rows    (num_rows),
    .ph1_done    (ph1_done),
    .jif         (jif),
    .pass_idx    (pass_idx),
    .busy        (busy),
    .merge_done  (merge_done),
    .result_base (result_base),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_valid = 0;
  int cyc = 0;
  int held = 0;
  logic auto_done = 1'b0;
  logic manual_done = 1'b0;
  logic [43:0] expq[$];
  int dq[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] pk(input int a, input int b,
                                     input int d, input int l);
    return {a[9:0], b[9:0], d[9:0], l[9:0]};
  endfunction

  function automatic logic [39:0] jv();
    return {jif.job_src_a, jif.job_src_b, jif.job_dst, jif.job_run_len};
  endfunction

  function automatic logic [57:0] outs();
    return {jif.job_valid, busy, merge_done, err,
            pass_idx, result_base, jv()};
  endfunction

  task automatic push(input int a, input int b, input int d,
                      input int l, input int p);
    expq.push_back({pk(a, b, d, l), p[3:0]});
  endtask

  task automatic push8();
    push(0, 1, 512, 1, 0);
    push(2, 3, 514, 1, 0);
    push(4, 5, 516, 1, 0);
    push(6, 7, 518, 1, 0);
    push(512, 514, 0, 2, 1);
    push(516, 518, 4, 2, 1);
    push(0, 4, 512, 4, 2);
  endtask

  task automatic push4();
    push(0, 1, 512, 1, 0);
    push(2, 3, 514, 1, 0);
    push(512, 514, 0, 2, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    num_rows = n[AW-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_ph1();
    ph1_done = 1'b1;
    tick();
    ph1_done = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!merge_done && n < lim) begin
      tick();
      n++;
    end
    check("merge_done", {63'd0, merge_done}, 64'd1);
  endtask

  task automatic release_done();
    repeat (held) dq.push_back(cyc);
    held = 0;
    auto_done = 1'b1;
  endtask

  // Engine model: done pulses from a due-cycle queue or a manual strobe.
  initial begin
    int tmp;
    jif.job_done = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (manual_done) begin
        jif.job_done = 1'b1;
      end else if (auto_done && dq.size() > 0 && dq[0] <= cyc) begin
        tmp = dq.pop_front();
        jif.job_done = 1'b1;
      end else begin
        jif.job_done = 1'b0;
      end
    end
  end

  initial begin
    logic [43:0] e;
    forever begin
      @(negedge clk);
      if (jif.job_valid) n_valid++;
      if (rst_n && jif.job_valid && jif.job_ready) begin
        n_acc++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_job: got %0h expected none",
                   {jv(), pass_idx});
        end else begin
          e = expq.pop_front();
          check("job", {20'd0, jv(), pass_idx}, {20'd0, e});
        end
        if (auto_done) dq.push_back(cyc + 3);
        else held++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, v0, n;
    int sz[3];
    int se[3];
    sz = '{1, 6, 0};
    se = '{0, 1, 1};
    jif.job_ready = 1'b0;
    repeat (2) tick();
    check("reset_outputs", {6'd0, outs()}, 64'd0);
    rst_n = 1'b1;
    tick();

    // nominal 8 rows
    auto_done = 1'b1;
    jif.job_ready = 1'b1;
    push8();
    a0 = n_acc;
    do_start(8);
    check("busy", {63'd0, busy}, 64'd1);
    do_ph1();
    check("ph1_to_valid", {63'd0, jif.job_valid}, 64'd1);
    wait_done(200);
    check("nom_result", {54'd0, result_base}, 64'd512);
    check("nom_err", {63'd0, err}, 64'd0);
    check("nom_jobs", 64'(n_acc - a0), 64'd7);
    check("nom_sb_empty", 64'(expq.size()), 64'd0);
    repeat (2) tick();

    // degenerate and illegal sizes
    for (int i = 0; i < 3; i++) begin
      v0 = n_valid;
      do_start(sz[i]);
      if (sz[i] == 1) do_ph1();
      wait_done(10);
      check("size_err", {63'd0, err}, 64'(se[i]));
      check("size_base", {54'd0, result_base}, 64'd0);
      check("size_nojob", 64'(n_valid - v0), 64'd0);
      repeat (2) tick();
    end

    // inflight limit
    auto_done = 1'b0;
    push8();
    a0 = n_acc;
    do_start(8);
    do_ph1();
    repeat (8) tick();
    check("inflight_accepts", 64'(n_acc - a0), 64'd2);
    check("inflight_hold", {63'd0, jif.job_valid}, 64'd0);
    manual_done = 1'b1;
    held--;
    tick();
    manual_done = 1'b0;
    check("offer_after_done", {63'd0, jif.job_valid}, 64'd1);
    release_done();
    wait_done(300);
    check("inflight_sb_empty", 64'(expq.size()), 64'd0);
    repeat (2) tick();

    // backpressure and pause
    jif.job_ready = 1'b0;
    push4();
    a0 = n_acc;
    do_start(4);
    do_ph1();
    for (int i = 0; i < 5; i++) begin
      check("bp_stable", {23'd0, jif.job_valid, jv()},
            {23'd0, 1'b1, pk(0, 1, 512, 1)});
      tick();
    end
    pause = 1'b1;
    tick();
    check("pause_hold", {23'd0, jif.job_valid, jv()},
          {23'd0, 1'b1, pk(0, 1, 512, 1)});
    jif.job_ready = 1'b1;
    tick();
    repeat (3) tick();
    check("pause_block", {63'd0, jif.job_valid}, 64'd0);
    check("pause_accepts", 64'(n_acc - a0), 64'd1);
    pause = 1'b0;
    wait_done(200);
    check("bp_result", {54'd0, result_base}, 64'd0);
    check("bp_sb_empty", 64'(expq.size()), 64'd0);
    repeat (2) tick();

    // accept and done in the same cycle
    auto_done = 1'b0;
    jif.job_ready = 1'b0;
    push8();
    a0 = n_acc;
    do_start(8);
    do_ph1();
    jif.job_ready = 1'b1;
    tick();
    jif.job_ready = 1'b0;
    check("b2b_offer", {63'd0, jif.job_valid}, 64'd1);
    jif.job_ready = 1'b1;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    held--;
    repeat (4) tick();
    check("sim_accepts", 64'(n_acc - a0), 64'd3);
    check("sim_hold", {63'd0, jif.job_valid}, 64'd0);
    release_done();
    wait_done(300);
    check("sim_sb_empty", 64'(expq.size()), 64'd0);
    repeat (2) tick();

    // reset during pass 1
    push8();
    do_start(8);
    do_ph1();
    n = 0;
    while (pass_idx != 4'd1 && n < 100) begin
      tick();
      n++;
    end
    check("reach_pass1", {60'd0, pass_idx}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {6'd0, outs()}, 64'd0);
    expq.delete();
    dq.delete();
    held = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // spurious done in IDLE, then restart with 4 rows
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    check("spurious_err", {63'd0, err}, 64'd1);
    tick();
    push4();
    a0 = n_acc;
    do_start(4);
    check("err_cleared", {63'd0, err}, 64'd0);
    do_ph1();
    wait_done(200);
    check("restart_result", {54'd0, result_base}, 64'd0);
    check("restart_jobs", 64'(n_acc - a0), 64'd3);
    check("restart_sb_empty", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hams_merge_sched.md
# hams_merge_sched

Merge-phase scheduler for the HAMS sorter. After the bitonic phase (`bitonic_sort_done`) has left every work-memory row holding one sorted group of `NUM_ELEMENTS` keys, this block sequences the log2(num_rows) merge passes. Each pass is a series of merge jobs (two source runs to one destination) issued to the merge engine over a valid/ready handshake. Runs ping-pong between the lower and upper halves of the work memories, with up to `MAX_INFLIGHT` jobs outstanding.

## Interface
Parameters:
- `MEM_DEPTH`, 1024, rows per work memory; `DATA_ROWS = MEM_DEPTH/2` (data half / scratch half).
- `ADDR_WIDTH`, `$clog2(MEM_DEPTH)`, row address width.
- `MAX_INFLIGHT`, 2, maximum accepted-but-not-done jobs.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level request; sampled in IDLE.
- `pause`  in  1  blocks presentation of new jobs.
- `num_rows`  in  ADDR_WIDTH  sorted rows to merge; latched when `start` is accepted.
- `ph1_done`  in  1  bitonic phase complete.
- `job_valid`  out  1  job offered.
- `job_ready`  in  1  engine accepts the job.
- `job_src_a`, `job_src_b`, `job_dst`  out  ADDR_WIDTH each  run base rows.
- `job_run_len`  out  ADDR_WIDTH  rows per source run.
- `job_done`  in  1  one-cycle pulse per completed job.
- `pass_idx`  out  4  current pass number.
- `busy`  out  1  high when not in IDLE or DONE.
- `merge_done`  out  1  high in DONE.
- `result_base`  out  ADDR_WIDTH  base row of the final sorted data.
- `err`  out  1  sticky error flag; cleared on the next accepted `start`.

## Operation
- FSM states: IDLE, WAIT_PH1, ISSUE, DRAIN, DONE.
- **IDLE**: on `start`, latch `num_rows` and clear `err`.
  - If `num_rows` is 0, not a power of two, or greater than DATA_ROWS: set `err` and go to DONE.
  - Otherwise go to WAIT_PH1.
- **WAIT_PH1**:
  - On `ph1_done` with `num_rows==1`: go to DONE with `result_base=0`.
  - On `ph1_done` otherwise: go to ISSUE with `run_len=1`, `src_base=0`, `dst_base=DATA_ROWS`, `k=0`.
- **ISSUE**: job k of the pass is
  - `src_a = src_base + 2*run_len*k`
  - `src_b = src_a + run_len`
  - `dst = dst_base + 2*run_len*k`
  - All arithmetic is ADDR_WIDTH-bit and never wraps, because the range is checked at start.
  - When job k is accepted: if it is the last job (`k == num_rows/(2*run_len) - 1`), go to DRAIN; otherwise k++.
- **DRAIN**: once `inflight==0`:
  - If `2*run_len == num_rows`: go to DONE with `result_base = dst_base`.
  - Otherwise: double `run_len`, swap `src_base`/`dst_base`, `pass_idx++`, `k=0`, go to ISSUE.
- **DONE**: hold `merge_done`; go to IDLE when `start` is low.
- **Inflight counter**:
  - +1 on accept (`job_valid && job_ready`), −1 on `job_done`.
  - Both in the same cycle: unchanged.
  - `job_done` with `inflight==0`: ignored and sets `err`.
- **Presentation rules**:
  - `job_valid` is asserted only when `inflight < MAX_INFLIGHT` (post-decrement) and `!pause`.
  - Once asserted, `job_valid` and all job fields stay stable until accepted, even if `pause` rises.

## Timing
- Reset values:
  - State IDLE; `job_valid`, `busy`, `merge_done`, `err` = 0.
  - Job fields, `pass_idx`, `result_base` = 0; `inflight` = 0.
- Reset mid-operation: immediately abandons the pass. The engine is reset by the same `rst_n`.
- All outputs are registered.
- Start-up latency:
  - `start` in IDLE → WAIT_PH1 next cycle.
  - `ph1_done` seen → `job_valid` high on the following cycle.
- Back-to-back issue: a job accepted in cycle t allows the next `job_valid` in cycle t+1 if the inflight limit permits.
- The last `job_done` of a pass (inflight reaches 0) leads, one cycle later, to either the first `job_valid` of the next pass or `merge_done`.

## Structure
- `hams_pkg` gets:
  - `merge_job_t` (packed struct: `src_a`, `src_b`, `dst`, `run_len`).
  - `HAMS_MERGE_MAX_INFLIGHT` constant.
- Port fields map to the struct members.
- A single sub-module is natural: `hams_merge_jobgen`, the per-pass k counter and address generator, with `load`/`advance`/`last` outputs.

## Test plan
- **Nominal 8 rows**: `num_rows=8`, `ready=1`, `done` 3 cycles after accept. Expected 7 jobs with fields (src_a, src_b, dst, run_len):
  - Pass 0: (0,1,512,1), (2,3,514,1), (4,5,516,1), (6,7,518,1).
  - Pass 1: (512,514,0,2), (516,518,4,2).
  - Pass 2: (0,4,512,4).
  - Then `merge_done=1`, `result_base=512`, `err=0`.
- **Degenerate and illegal sizes**:
  - `num_rows=1` → no `job_valid`; `merge_done` with `result_base=0`.
  - `num_rows=6` or 0 → `err=1`, `merge_done`, no jobs.
- **Inflight limit**: `job_done` withheld → exactly 2 accepts, then `job_valid` stays low. One `done` → next job offered the following cycle.
- **Backpressure and pause**:
  - `job_ready=0` for 5 cycles → fields stable.
  - `pause` raised mid-pass with valid high → job held until accepted, then no new job until `pause` falls.
- **Simultaneous events and spurious done**:
  - Accept and `job_done` in the same cycle → inflight unchanged.
  - Spurious `job_done` in IDLE → `err=1`.
- **Reset mid-pass**: `rst_n` low during pass 1 → all outputs return to reset values. A restart with `num_rows=4` completes in 3 jobs with `result_base=0`.
